// File: rtl/mem_responder.sv
// Single-port 16-bit memory responder: captures a request in IDLE, waits
// WAIT_STATES cycles, then completes with a one-cycle Ready pulse.
module mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        WE,
  input  logic [15:0] Addr,
  input  logic [15:0] Din,
  output logic        Ready,
  output logic [15:0] Dout,
  output logic        Busy
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam bit          NO_WAIT = (WAIT_STATES == 32'd0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                capture_c;
  logic                direct_c;
  logic                finish_c;
  logic                load_c;
  logic                acc_we_c;
  logic                mem_we_c;
  logic [ADDR_W-1:0]   acc_addr_c;
  logic [DATA_W-1:0]   acc_data_c;
  logic                unused_addr_c;

  // Upper address bits alias away by design.
  assign unused_addr_c = ^Addr[15:ADDR_W];

  // With zero wait states the access completes on the capture edge itself,
  // so it must be served straight from the ports rather than the capture regs.
  assign capture_c  = (state == IDLE) && Req && !Reset;
  assign direct_c   = capture_c && NO_WAIT;
  assign finish_c   = (state == WAIT) && (cnt == CNT_W'(1)) && !Reset;
  assign load_c     = direct_c || finish_c;
  assign acc_we_c   = direct_c ? WE : we_q;
  assign acc_addr_c = direct_c ? Addr[ADDR_W-1:0] : addr_q;
  assign acc_data_c = direct_c ? Din : din_q;
  assign mem_we_c   = load_c && acc_we_c;

  assign Ready = (state == RESP);
  assign Busy  = (state != IDLE);

  // Control FSM, capture registers and response data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      Dout   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Req) begin
            we_q   <= WE;
            addr_q <= Addr[ADDR_W-1:0];
            din_q  <= Din;
            if (NO_WAIT) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (load_c) Dout <= acc_we_c ? acc_data_c : mem[acc_addr_c];
    end
  end

  // Storage is not reset; writes are gated by the FSM so an abort leaves it intact.
  always_ff @(posedge Clk) begin
    if (mem_we_c) mem[acc_addr_c] <= acc_data_c;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, which sets the internal memory depth to 2^ADDR_W words of 16 bits.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, legal range 0..7, which sets the number of wait cycles inserted before each response.
REQ-003 Port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port Reset  input  1  reset, asynchronous, active-high.
REQ-005 Port Req  input  1  request strobe from the initiator.
REQ-006 Port WE  input  1  access type: 1 = write, 0 = read.
REQ-007 Port Addr  input  16  word address; only Addr[ADDR_W-1:0] is used.
REQ-008 Port Din  input  16  write data.
REQ-009 Port Ready  output  1  one-cycle completion pulse.
REQ-010 Port Dout  output  16  registered response data.
REQ-011 Port Busy  output  1  high while a transaction is in flight.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-013 In IDLE, Req=1 at a rising edge (edge N) SHALL capture WE, Addr[ADDR_W-1:0] and Din into internal registers.
REQ-014 At edge N, the FSM SHALL go to WAIT with the down-counter loaded to WAIT_STATES, or directly to RESP when WAIT_STATES=0.
REQ-015 In WAIT, the counter SHALL decrement on each edge, and the FSM SHALL enter RESP on the edge at which the counter leaves 1.
REQ-016 Ready SHALL be high only in RESP, which occupies exactly the one cycle following edge N+WAIT_STATES.
REQ-017 RESP SHALL return to IDLE on the next edge unconditionally.
REQ-018 Busy SHALL be high in WAIT and RESP, and low in IDLE, decoded from the state register.
REQ-019 Req, WE, Addr and Din SHALL be ignored in WAIT and RESP; captured values alone determine the transaction.
REQ-020 For a captured write, mem[addr] SHALL update on the edge entering RESP, and Dout SHALL load the written data on that same edge.
REQ-021 For a captured read, Dout SHALL load mem[addr] on the edge entering RESP.
REQ-022 Dout SHALL hold its value at all times other than the RESP-entry edge.
REQ-023 An initiator holding Req high through the Ready cycle SHALL be treated as issuing a new request, captured at the RESP-to-IDLE+1 edge, so the minimum request spacing is WAIT_STATES+2 cycles.
REQ-024 Address bits above ADDR_W-1 SHALL be ignored, so addresses alias modulo 2^ADDR_W.
REQ-025 A read issued to an address immediately after a write to the same address SHALL return the new data.

Reset
REQ-026 Reset=1 SHALL immediately force the state to IDLE, the counter to 0, Ready=0, Busy=0 and Dout=16'h0000, independent of Clk.
REQ-027 Reset asserted before the RESP-entry edge of a write SHALL abort that write, leaving the memory word unchanged.
REQ-028 Memory array contents SHALL be unaffected by Reset; power-up contents are undefined.
REQ-029 The first edge after Reset deasserts with Req=1 SHALL be accepted as a normal IDLE capture.

Verification
REQ-030 Scenario 1 (WAIT_STATES=2): write 16'hBEEF to 16'h0005, then read 16'h0005 -> each Ready occurs in the cycle after edge N+2, and the read gives Dout=16'hBEEF.
REQ-031 Scenario 2 (WAIT_STATES=0): read 16'h0005 -> Ready occurs in the cycle after edge N, Busy is high for 1 cycle, and Dout=16'hBEEF.
REQ-032 Scenario 3 (aliasing): write 16'h1234 to 16'h0105 with ADDR_W=8, then read 16'h0005 -> Dout=16'h1234.
REQ-033 Scenario 4 (Req held high for 3 transactions, WAIT_STATES=2): -> Ready pulses are 4 cycles apart, and Addr/Din changes applied during WAIT have no effect.
REQ-034 Scenario 5 (reset mid-operation): assert Reset in WAIT of a write of 16'hAAAA to 16'h0007 that was preceded by a write of 16'h5555 to the same address -> Busy=0 and Dout=0 immediately, and a subsequent read returns 16'h5555.
REQ-035 Scenario 6 (Req=0 for 10 cycles): -> Ready=0, Busy=0 and Dout unchanged throughout.
